// File: rtl/mem_store_buffer.sv
// Posted-write store buffer in front of the data memory: queues stores, drains them
// in cycles without a missing load, and forwards pending store data to loads.
module mem_store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_HEIGHT = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic                       flush,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_error,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_write,
    output logic                       mem_read,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // exactly one response (rsp_valid) follows on the next cycle.

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_error_q, rsp_error_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              full;
    logic              accept;
    logic              in_range;
    logic              push;
    logic              load;
    logic              hit;
    logic              miss;
    logic              drain;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  idx;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign req_ready = !full && !flush;
    assign accept    = req_valid && req_ready;
    assign in_range  = (req_addr < ADDR_W'(MEM_HEIGHT));
    assign push      = accept && req_write && in_range;
    assign load      = accept && !req_write && in_range;
    assign miss      = load && !hit;
    assign drain     = !miss && (count_q != '0);

    // Scan oldest to youngest so the last match left standing is the youngest store.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[idx] == req_addr)) begin
                hit      = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            addr_d[wr_ptr_q] = req_addr;
            data_d[wr_ptr_q] = req_wdata;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (drain) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rsp_valid_d = accept;
        rsp_error_d = accept && !in_range;
        rsp_rdata_d = '0;
        if (load) begin
            rsp_rdata_d = hit ? fwd_data : mem_rdata;
        end
    end

    // Memory strobes are forced low for as long as reset is held.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            if (miss) begin
                mem_read = 1'b1;
                mem_addr = req_addr;
            end else if (drain) begin
                mem_write = 1'b1;
                mem_addr  = addr_q[rd_ptr_q];
                mem_wdata = data_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Entry storage is only meaningful below count_q, so it needs no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_rdata = rsp_rdata_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);

endmodule
